pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Central sequencer for the 5-stage MIPS pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Drives per-register enables and bubble-flushes, the PC branch-select, and ALU operand forwarding selects.
- Runs a small FSM for data-memory wait states and an orderly halt/drain.
- Keeps saturating stall/flush performance counters.

## Interface

Parameters
- CNT_W, 32, width of performance counters
- MAX_WAIT, 255, memory-wait cycles before mem_timeout sets
- DRAIN_CYCLES, 4, advancing cycles from halt acceptance to HALTED

Ports
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs_addr, id_rt_addr  in  5  source registers of the instruction in ID (IF_ID output)
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_rs_addr, ex_rt_addr  in  5  ID_EX RS/RT addresses
- ex_rd_addr  in  5  EX destination after the RegDst mux
- ex_mem_read  in  1  ID_EX MemRead
- mem_rd_addr  in  5  EX_MEM destination
- mem_reg_write  in  1  EX_MEM RegWrite
- mem_branch, mem_zero, mem_jump  in  1  EX_MEM Branch, zeroflag, Jump
- dmem_req  in  1  EX_MEM MemRead or MemWrite
- dmem_ready  in  1  data memory completes access this cycle
- wb_rd_addr  in  5  MEM_WB destination
- wb_reg_write  in  1  MEM_WB RegWrite
- halt_req  in  1  request drain-and-halt (level, sampled in RUN)
- resume  in  1  leave HALTED (pulse)
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (all control bits 0) instead of the input
- pc_sel_branch  out  1  PC loads EX_MEM BranchAddress
- forward_a, forward_b  out  2  operand select: 00 register file, 10 EX_MEM ALU result, 01 MEM_WB writeback data
- halted  out  1  pipeline drained and frozen
- mem_timeout  out  1  sticky; a wait exceeded MAX_WAIT
- stall_cycles, flush_events  out  CNT_W  saturating counters

## Operation

FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN.

Signal definitions
- freeze = dmem_req & !dmem_ready
- taken = (mem_branch & mem_zero) | mem_jump
- load_use = ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs_addr | (id_uses_rt & ex_rd_addr==id_rt_addr))

Cycle priority in RUN, MEM_WAIT and DRAIN, highest first:
- freeze: all enables 0, all flushes 0, pc_sel_branch 0.
- taken: all enables 1; pc_sel_branch 1; if_id_flush, id_ex_flush, ex_mem_flush 1; flush_events +1. Overrides load_use.
- load_use: pc_en 0, if_id_en 0; id_ex_flush 1; all other enables 1.
- Otherwise all enables 1 and no flushes.

DRAIN-specific behaviour
- if_id_flush 1 and pc_en 0 on every advancing cycle.
- On taken, pc_en is 1, so PC captures the target for resume.
- On load_use, IF/ID holds (if_id_flush 0).

Transitions
- RUN: freeze → MEM_WAIT. Otherwise, if halt_req → DRAIN, loading the drain counter with DRAIN_CYCLES.
- MEM_WAIT: leave on the dmem_ready cycle, returning to the state that was active when the wait began (RUN or DRAIN).
- DRAIN: the counter decrements only on advancing cycles (not freeze, not load_use). At 0 → HALTED.
- HALTED: all enables 0, halted 1. resume → RUN; halt_req is ignored until the next RUN cycle.

Forwarding (combinational, no state), evaluated per operand:
- forward_a = 10 if mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==ex_rs_addr.
- Else 01 if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==ex_rs_addr.
- Else 00.
- forward_b uses the same rule with ex_rt_addr.

Counters and timeout
- stall_cycles increments on every freeze or load_use cycle.
- The wait counter counts consecutive freeze cycles. On reaching MAX_WAIT, mem_timeout sets and stays set until reset; the FSM stays in MEM_WAIT.
- Counters saturate at all-ones and clear only on reset.

## Timing

- While rst_n is low:
  - state RUN; all enables 0; flushes 0; pc_sel_branch 0; forward 00.
  - halted 0; mem_timeout 0; counters 0.
- Enables, flushes, pc_sel_branch and forward selects are combinational from inputs and state, valid within the same cycle. They act at the next clk edge.
- Load-use costs exactly 1 bubble; a taken branch costs 3 squashed slots.
- A freeze cycle that also shows taken produces no redirect; the redirect occurs on the dmem_ready cycle.
- Reset asserted mid-wait or mid-drain returns to RUN immediately; counters clear.
- halt_req and taken in the same RUN cycle: the redirect occurs, and DRAIN is entered on the same edge.

## Structure

- Package pipe_ctrl_pkg holds:
  - state enum ST_RUN, ST_MEM_WAIT, ST_DRAIN, ST_HALTED
  - forward constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- Sub-module forward_unit: purely combinational, instantiated twice or once with both operands. Everything else stays in pipeline_hazard_ctrl.

## Test plan

- lw $2 in EX (ex_mem_read=1, ex_rd=2), ID reads rs=2 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1; next cycle all enables 1.
- mem_rd=3 with mem_reg_write, wb_rd=3 with wb_reg_write, ex_rs=3 → forward_a=10. Change mem_rd to 0 → forward_a=01. Dest 0 in both → 00.
- mem_branch=1, mem_zero=1 → pc_sel_branch=1; three flushes=1; flush_events=1. With load_use also true, there is no stall.
- dmem_req=1, dmem_ready=0 for 5 cycles, then 1 → all enables 0 for 5 cycles, then 1; stall_cycles=5. With MAX_WAIT=3, mem_timeout rises after the third wait cycle and stays high.
- halt_req in RUN with no hazards → DRAIN for 4 cycles with pc_en=0 and if_id_flush=1, then halted=1. resume pulse → RUN, halted=0. Repeat with one load_use during DRAIN → 5 cycles.
- Assert rst_n=0 in MEM_WAIT → outputs at reset values immediately; after release, RUN with counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// ALU operand forwarding select for one source register; EX_MEM beats MEM_WB.
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == src_addr)
      fwd_sel = FWD_MEM;
    else if (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == src_addr)
      fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward sequencer for the 5-stage pipeline, with
// memory wait states, halt/drain FSM and saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MAX_WAIT     = 255,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs_addr,
  input  logic [4:0]       ex_rt_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_sel_branch,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       dbg_state
);

  localparam int WAIT_W  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e             state_q, state_d, ret_q, ret_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [WAIT_W-1:0]  wait_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_q, flush_q;
  logic [1:0]         fwd_a_raw, fwd_b_raw;

  // Data-memory handshake: the access is outstanding while dmem_req is high
  // and completes in the cycle dmem_ready is also high; until then the whole
  // pipeline holds.
  logic freeze, taken, load_use, lu_stall, active, draining, advancing;
  assign freeze    = dmem_req & ~dmem_ready;
  assign taken     = (mem_branch & mem_zero) | mem_jump;
  assign load_use  = ex_mem_read & (ex_rd_addr != 5'd0) &
                     ((ex_rd_addr == id_rs_addr) | (id_uses_rt & (ex_rd_addr == id_rt_addr)));
  assign lu_stall  = load_use & ~taken;
  assign active    = (state_q != ST_HALTED);
  assign draining  = (state_q == ST_DRAIN) | ((state_q == ST_MEM_WAIT) & (ret_q == ST_DRAIN));
  assign advancing = ~freeze & ~lu_stall;

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    if (rst_n && active && !freeze) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (taken) begin
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (draining) begin
        // Draining: stop fetching and feed bubbles behind the last instruction.
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d = ST_MEM_WAIT;
          ret_d   = ST_RUN;
        end else if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (freeze) begin
          state_d = ST_MEM_WAIT;
          ret_d   = ST_DRAIN;
        end else if (advancing) begin
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!freeze) begin
          state_d = ret_q;
          // The completing cycle is itself an advancing drain cycle.
          if (ret_q == ST_DRAIN && advancing) begin
            if (drain_q <= DRAIN_W'(1)) begin
              state_d = ST_HALTED;
              drain_d = '0;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
        end
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      drain_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      drain_q <= drain_d;
      if (active && freeze) begin
        if (int'(wait_q) < MAX_WAIT) wait_q <= wait_q + 1'b1;
        if (int'(wait_q) + 1 >= MAX_WAIT) timeout_q <= 1'b1;
      end else begin
        wait_q <= '0;
      end
      if (active && (freeze || lu_stall) && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (active && !freeze && taken && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  forward_unit u_fwd_a (
    .src_addr      (ex_rs_addr),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_a_raw)
  );

  forward_unit u_fwd_b (
    .src_addr      (ex_rt_addr),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_b_raw)
  );

  assign forward_a    = rst_n ? fwd_a_raw : FWD_RF;
  assign forward_b    = rst_n ? fwd_b_raw : FWD_RF;
  assign halted       = (state_q == ST_HALTED);
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a
// behavioural model of the stall/flush/forward/halt rules.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W        = 6;
  localparam int MAX_WAIT     = 3;
  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [4:0]       mem_rd_addr, wb_rd_addr;
  logic             id_uses_rt, ex_mem_read, mem_reg_write, mem_branch, mem_zero, mem_jump;
  logic             dmem_req, dmem_ready, wb_reg_write, halt_req, resume;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch;
  logic [1:0]       forward_a, forward_b, dbg_state;
  logic             halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_halt, m_wait, m_drain, m_tmo;
  int m_left, m_wait_cnt, m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .pc_sel_branch(pc_sel_branch),
    .forward_a(forward_a), .forward_b(forward_b), .halted(halted),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit f_frz();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit f_tk();
    return (mem_branch && mem_zero) || mem_jump;
  endfunction

  function automatic bit f_lu();
    return ex_mem_read && ex_rd_addr != 0 &&
           (ex_rd_addr == id_rs_addr || (id_uses_rt && ex_rd_addr == id_rt_addr));
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex/ex_mem flush, pc_sel}
  function automatic logic [8:0] exp_ctrl();
    if (!rst_n || m_halt || f_frz()) return 9'b0;
    if (f_tk())    return 9'b1_1111_1111;
    if (f_lu())    return 9'b0_0111_0100;
    if (m_drain)   return 9'b0_1111_1000;
    return 9'b1_1111_0000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (!rst_n) return 2'b00;
    if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == src) return 2'b10;
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_wait = 0; m_drain = 0; m_tmo = 0;
    m_left = 0; m_wait_cnt = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_update();
    bit frz, tk, lu, adv;
    frz = f_frz(); tk = f_tk(); lu = f_lu();
    if (m_halt) begin
      m_wait_cnt = 0;
      if (resume) m_halt = 0;
    end else if (frz) begin
      m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      m_wait_cnt++;
      if (m_wait_cnt >= MAX_WAIT) m_tmo = 1;
      m_wait = 1;
    end else begin
      m_wait_cnt = 0;
      if (tk) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      if (lu && !tk) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      adv = !(lu && !tk);
      if (m_drain) begin
        if (adv) begin
          m_left--;
          if (m_left == 0) begin
            m_halt  = 1;
            m_drain = 0;
          end
        end
      end else if (!m_wait && halt_req) begin
        m_drain = 1;
        m_left  = DRAIN_CYCLES;
      end
      m_wait = 0;
    end
  endtask

  task automatic check_all();
    chk("ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch}, exp_ctrl());
    chk("forward_a", forward_a, exp_fwd(ex_rs_addr));
    chk("forward_b", forward_b, exp_fwd(ex_rt_addr));
    chk("halted", halted, m_halt);
    chk("mem_timeout", mem_timeout, m_tmo);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_events", flush_events, m_flush);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs_addr = 0; id_rt_addr = 0; id_uses_rt = 0;
    ex_rs_addr = 0; ex_rt_addr = 0; ex_rd_addr = 0; ex_mem_read = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_branch = 0; mem_zero = 0; mem_jump = 0;
    dmem_req = 0; dmem_ready = 0; wb_rd_addr = 0; wb_reg_write = 0;
    halt_req = 0; resume = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_rd_addr = 2; id_rs_addr = 2;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    // Forwarding conditions present during reset must still read as 00.
    mem_rd_addr = 3; mem_reg_write = 1; ex_rs_addr = 3; ex_rt_addr = 3;
    @(negedge clk);
    step();
    chk("rst_fwd_a", forward_a, 2'b00);
    chk("rst_pc_en", pc_en, 1'b0);
    idle();
    @(negedge clk);
    rst_n = 1;
    step();

    // Load-use: one bubble
    set_load_use();
    #1;
    chk("lu_pc_en", pc_en, 1'b0);
    chk("lu_id_ex_flush", id_ex_flush, 1'b1);
    step();
    idle();
    #1;
    chk("lu_stall_cnt", stall_cycles, 1);
    chk("lu_after_pc_en", pc_en, 1'b1);
    step();

    // Forwarding priority
    mem_rd_addr = 3; mem_reg_write = 1; wb_rd_addr = 3; wb_reg_write = 1; ex_rs_addr = 3;
    #1 chk("fwd_mem", forward_a, 2'b10);
    step();
    mem_rd_addr = 0;
    #1 chk("fwd_wb", forward_a, 2'b01);
    step();
    wb_rd_addr = 0;
    #1 chk("fwd_zero_dest", forward_a, 2'b00);
    step();
    idle();

    // Taken branch, then taken with a simultaneous load-use
    mem_branch = 1; mem_zero = 1;
    #1 chk("br_pc_sel", pc_sel_branch, 1'b1);
    step();
    #1 chk("br_flush_cnt", flush_events, 1);
    set_load_use();
    #1 chk("br_lu_pc_en", pc_en, 1'b1);
    step();
    idle();
    #1 chk("br_lu_stall_cnt", stall_cycles, 1);
    step();

    // Five wait cycles, timeout after the third
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("frz_mem_wb_en", mem_wb_en, 1'b0);
      if (i == 2) chk("tmo_before", mem_timeout, 1'b0);
      if (i == 3) chk("tmo_after", mem_timeout, 1'b1);
      step();
    end
    dmem_ready = 1;
    #1 chk("frz_release_en", pc_en, 1'b1);
    chk("frz_stall_cnt", stall_cycles, 6);
    step();
    idle();
    #1 chk("tmo_sticky", mem_timeout, 1'b1);
    step();

    // Halt and drain with no hazards
    halt_req = 1;
    step();
    halt_req = 0;
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      #1 chk("drain_pc_en", pc_en, 1'b0);
      chk("drain_if_id_flush", if_id_flush, 1'b1);
      step();
    end
    #1 chk("halted_set", halted, 1'b1);
    resume = 1;
    step();
    resume = 0;
    #1 chk("resumed", halted, 1'b0);
    step();

    // Drain stretched by one load-use
    halt_req = 1;
    step();
    halt_req = 0;
    for (int i = 0; i < DRAIN_CYCLES + 1; i++) begin
      if (i == 1) set_load_use(); else idle();
      #1 chk("drain_lu_not_halted", halted, 1'b0);
      step();
    end
    idle();
    #1 chk("drain_lu_halted", halted, 1'b1);
    resume = 1;
    step();
    resume = 0;
    step();

    // Reset in the middle of a memory wait
    dmem_req = 1; dmem_ready = 0;
    step();
    step();
    rst_n = 0;
    model_reset();
    #1;
    chk("midrst_stall", stall_cycles, 0);
    chk("midrst_tmo", mem_timeout, 1'b0);
    step();
    idle();
    rst_n = 1;
    #1 chk("postrst_pc_en", pc_en, 1'b1);
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      id_rs_addr    = 5'($urandom_range(0, 3));
      id_rt_addr    = 5'($urandom_range(0, 3));
      ex_rs_addr    = 5'($urandom_range(0, 3));
      ex_rt_addr    = 5'($urandom_range(0, 3));
      ex_rd_addr    = 5'($urandom_range(0, 3));
      mem_rd_addr   = 5'($urandom_range(0, 3));
      wb_rd_addr    = 5'($urandom_range(0, 3));
      id_uses_rt    = ($urandom_range(0, 1) == 0);
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      mem_reg_write = ($urandom_range(0, 1) == 0);
      wb_reg_write  = ($urandom_range(0, 1) == 0);
      mem_branch    = ($urandom_range(0, 3) == 0);
      mem_zero      = ($urandom_range(0, 1) == 0);
      mem_jump      = ($urandom_range(0, 7) == 0);
      dmem_req      = ($urandom_range(0, 3) == 0);
      dmem_ready    = ($urandom_range(0, 1) == 0);
      halt_req      = ($urandom_range(0, 7) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
